// File: rtl/instruction_fetch_pkg.sv
// Shared state encoding for the instruction fetch sequencer.
package instruction_fetch_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch FIFO; head shows the oldest entry while not empty.
module fetch_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic [PTR_W:0]        occupancy
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occupancy <= occupancy + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Storage needs no reset: entries are only visible once pushed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (occupancy == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Streams a block of instruction words from imem port B to the decoder.
// Optional FETCH_PERF_CNT_EN adds a saturating stall-cycle counter output.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [COUNT_W-1:0]    inst_count,
    output logic                  busy,
    output logic                  done,
    output logic                  imem_read_req,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  inst_ready
`ifdef FETCH_PERF_CNT_EN
    ,output logic [31:0]          perf_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    fetch_state_t          state, state_nxt;
    logic [COUNT_W-1:0]    count_q;
    logic [COUNT_W-1:0]    issued_cnt;
    logic [COUNT_W-1:0]    accepted_cnt;
    logic                  inflight;
    logic                  pop;
    logic                  accept_start;
    logic                  fifo_empty;
    logic [PTR_W:0]        occupancy;
    logic [PTR_W:0]        projected;
    logic [DATA_WIDTH-1:0] fifo_head;

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (imem_read_data),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign accept_start = (state == IDLE) && start;
    assign inst_valid   = !fifo_empty;
    assign inst_data    = fifo_empty ? '0 : fifo_head;
    assign pop          = inst_valid && inst_ready;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // Slots the FIFO will hold after this cycle, counting the read already in flight.
    assign projected = occupancy + (PTR_W+1)'(inflight) - (PTR_W+1)'(pop);

    always_comb begin
        state_nxt     = state;
        imem_read_req = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (inst_count == '0) ? DONE : FETCH;
            end
            FETCH: begin
                imem_read_req = (issued_cnt < count_q) &&
                                (projected < (PTR_W+1)'(FIFO_DEPTH));
                // Leave on the last accept so done lands one cycle after it.
                if (accepted_cnt + COUNT_W'(pop) == count_q) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count_q        <= '0;
            issued_cnt     <= '0;
            accepted_cnt   <= '0;
            imem_read_addr <= '0;
            inflight       <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= imem_read_req;
            if (accept_start) begin
                count_q        <= inst_count;
                issued_cnt     <= '0;
                accepted_cnt   <= '0;
                imem_read_addr <= start_addr;
            end else begin
                if (imem_read_req) begin
                    issued_cnt     <= issued_cnt + COUNT_W'(1);
                    imem_read_addr <= imem_read_addr + ADDR_WIDTH'(1);
                end
                if (pop && state == FETCH) accepted_cnt <= accepted_cnt + COUNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || accept_start) begin
            perf_stall_cycles <= '0;
        end else if (state == FETCH && inst_valid && !inst_ready &&
                     perf_stall_cycles != 32'hFFFF_FFFF) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
